regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the multicycle core: NUM_RD combinational read
//  ports, one synchronous write port, x0 hardwired to zero, asynchronous clear of all state.
//  Adds a per-register busy scoreboard: decode marks a destination pending, writeback clears it.
//  Control uses RdBusy to stall operand fetch. Sits between decode/operand fetch and writeback.
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
//  NUM_RD  2   number of independent read ports (>=1)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous reset, active low
//  RdAddr      in   NUM_RD x AW    read addresses, one per port
//  RdData      out  NUM_RD x XLEN  read data, combinational
//  RdBusy      out  NUM_RD         1 = addressed register has a write pending
//  WrEn        in   1              writeback strobe
//  WrAddr      in   AW             writeback destination
//  WrData      in   XLEN           writeback data
//  IssueEn     in   1              mark IssueAddr pending
//  IssueAddr   in   AW             destination being issued
//  Flush       in   1              clear every busy bit (pipeline squash)
//  PendingCnt  out  $clog2(NREGS+1) registered count of busy registers
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all busy bits 0, PendingCnt 0. Mid-operation
//    reset discards any write or issue in flight; RdData reads 0, RdBusy 0 while held.
//  - Read: RdData[i] = (RdAddr[i]==0) ? 0 : reg[RdAddr[i]]; zero-cycle latency, no clock.
//  - Write: on posedge clk, if WrEn && WrAddr!=0, reg[WrAddr] <= WrData. Writes to x0 dropped.
//  - Busy bits, per posedge, in priority order:
//      1. Flush=1: all busy <= 0; IssueEn and busy-clear from WrEn ignored; data write still occurs.
//      2. IssueEn && IssueAddr!=0: busy[IssueAddr] <= 1.
//      3. WrEn && WrAddr!=0: busy[WrAddr] <= 0, unless IssueAddr==WrAddr with IssueEn (set wins:
//         a new producer has been issued).
//  - busy[0] is constant 0; issue of x0 ignored.
//  - PendingCnt: registered; equals popcount(busy) after every edge. Issue to an already-busy
//    register and writeback to a non-busy register leave it unchanged; simultaneous issue and
//    writeback to different registers leave it unchanged; Flush sets it to 0. Never wraps.
//  - RdBusy[i] = busy[RdAddr[i]] (see CONFIGURATION for same-cycle writeback).
// CONFIGURATION
//  Macro RF_WRITE_BYPASS_EN:
//  - defined: if WrEn && WrAddr==RdAddr[i] && WrAddr!=0, RdData[i]=WrData and RdBusy[i]=0 in
//    the same cycle (write-to-read forwarding; combinational path WrData->RdData).
//  - undefined: RdData[i] returns the pre-edge value and RdBusy[i] reflects the stored busy bit;
//    the new value is visible the cycle after the write.
// STRUCTURE
//  - Package regfile_pkg: XLEN/NREGS/NUM_RD defaults, AW localparam, typedefs addr_t
//    (logic [AW-1:0]) and word_t (logic [XLEN-1:0]).
//  - Sub-module rf_busy_table: busy vector, set/clear/flush priority, PendingCnt counter,
//    NUM_RD busy lookups. Top holds the data array, read muxes and bypass.
// TESTING
//  1. Reset: drive rst_n=0 mid-write of 0xDEADBEEF to x5 -> after release RdData(x5)=0,
//     PendingCnt=0, RdBusy=0 on all ports.
//  2. Write x0: WrEn, WrAddr=0, WrData=0xFFFFFFFF -> RdData(x0)=0; IssueEn on x0 -> PendingCnt 0.
//  3. Scoreboard: issue x3, x7 -> PendingCnt=2, RdBusy(x3)=1; writeback x3=0x12 -> busy(x3)=0,
//     PendingCnt=1, RdData(x3)=0x12 next cycle; re-issue x7 -> PendingCnt stays 1.
//  4. Same-edge issue+writeback x9 (x9 busy) -> busy(x9) stays 1, PendingCnt unchanged;
//     Flush with IssueEn on x4 in same cycle -> PendingCnt=0, busy(x4)=0.
//  5. Bypass: x10=0x1, WrEn x10=0xAB, RdAddr0=x10 same cycle -> with RF_WRITE_BYPASS_EN
//     RdData0=0xAB, RdBusy0=0; without, RdData0=0x1, then 0xAB next cycle.
//  6. Multi-port: NUM_RD=3, all ports read x31 after write 0x5A5A5A5A -> all three return it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file with busy scoreboard.
// Optional write-to-read forwarding is selected by the RF_WRITE_BYPASS_EN macro (see top).
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int AW         = $clog2(DEF_NREGS);

    typedef logic [AW-1:0]       addr_t;
    typedef logic [DEF_XLEN-1:0] word_t;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register pending-write scoreboard: flush > issue-set > writeback-clear priority,
// registered popcount of the busy vector and one busy lookup per read port.
module rf_busy_table
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int NUM_RD = DEF_NUM_RD,
    localparam int RF_AW = $clog2(NREGS),
    localparam int CNT_W = $clog2(NREGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_en,
    input  logic [RF_AW-1:0]             issue_addr,
    input  logic                         wr_en,
    input  logic [RF_AW-1:0]             wr_addr,
    input  logic                         flush,
    input  logic [NUM_RD-1:0][RF_AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic [CNT_W-1:0]             pending_cnt
);

    logic [NREGS-1:0] busy_reg, busy_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             set_hit, clr_hit;

    always_comb begin
        set_hit   = issue_en && (issue_addr != '0) && !flush;
        // A producer issued on the same edge owns the register, so its set beats the clear.
        clr_hit   = wr_en && (wr_addr != '0) && !flush && !(set_hit && (issue_addr == wr_addr));
        busy_next = busy_reg;
        cnt_next  = cnt_reg;
        if (flush) begin
            busy_next = '0;
            cnt_next  = '0;
        end else begin
            if (clr_hit) busy_next[wr_addr]    = 1'b0;
            if (set_hit) busy_next[issue_addr] = 1'b1;
            // Only real 0->1 / 1->0 transitions move the count, so it tracks popcount exactly.
            cnt_next = cnt_reg + CNT_W'(set_hit && !busy_reg[issue_addr])
                               - CNT_W'(clr_hit && busy_reg[wr_addr]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            assign rd_busy[gi] = busy_reg[rd_addr[gi]];
        end
    endgenerate

    assign pending_cnt = cnt_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (x0 = 0, NUM_RD async read ports, one sync write port) plus busy scoreboard.
// Define RF_WRITE_BYPASS_EN to forward a same-cycle writeback onto matching read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int NUM_RD = DEF_NUM_RD,
    localparam int RF_AW = $clog2(NREGS),
    localparam int CNT_W = $clog2(NREGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0][RF_AW-1:0] RdAddr,
    output logic [NUM_RD-1:0][XLEN-1:0]  RdData,
    output logic [NUM_RD-1:0]            RdBusy,
    input  logic                         WrEn,
    input  logic [RF_AW-1:0]             WrAddr,
    input  logic [XLEN-1:0]              WrData,
    input  logic                         IssueEn,
    input  logic [RF_AW-1:0]             IssueAddr,
    input  logic                         Flush,
    output logic [CNT_W-1:0]             PendingCnt
);

    logic [XLEN-1:0]   regs_reg [NREGS];
    logic [NUM_RD-1:0] stored_busy;

    rf_busy_table #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (IssueEn),
        .issue_addr  (IssueAddr),
        .wr_en       (WrEn),
        .wr_addr     (WrAddr),
        .flush       (Flush),
        .rd_addr     (RdAddr),
        .rd_busy     (stored_busy),
        .pending_cnt (PendingCnt)
    );

    // Flop-based storage: every register must clear on the asynchronous reset.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_reg[gi] = '0;
            end else begin : g_flop
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        regs_reg[gi] <= '0;
                    else if (WrEn && (WrAddr == RF_AW'(gi)))
                        regs_reg[gi] <= WrData;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_read
            logic            fwd_hit;
            logic [XLEN-1:0] stored_word;

            assign stored_word = (RdAddr[gi] == '0) ? '0 : regs_reg[RdAddr[gi]];
`ifdef RF_WRITE_BYPASS_EN
            // Gated by rst_n so a held reset never leaks in-flight write data.
            assign fwd_hit = rst_n && WrEn && (WrAddr != '0) && (WrAddr == RdAddr[gi]);
`else
            assign fwd_hit = 1'b0;
`endif
            assign RdData[gi] = fwd_hit ? WrData : stored_word;
            assign RdBusy[gi] = fwd_hit ? 1'b0 : stored_busy[gi];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (NUM_RD=3); expectations follow
// RF_WRITE_BYPASS_EN so the same bench serves both builds.
module tb_regfile_scoreboard;

    logic             clk;
    logic             rst_n;
    logic [2:0][4:0]  RdAddr;
    logic [2:0][31:0] RdData;
    logic [2:0]       RdBusy;
    logic             WrEn;
    logic [4:0]       WrAddr;
    logic [31:0]      WrData;
    logic             IssueEn;
    logic [4:0]       IssueAddr;
    logic             Flush;
    logic [5:0]       PendingCnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .RdBusy     (RdBusy),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .IssueEn    (IssueEn),
        .IssueAddr  (IssueAddr),
        .Flush      (Flush),
        .PendingCnt (PendingCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        $display("[%0t] wr=%0b x%0d=%h issue=%0b x%0d flush=%0b", $time, WrEn, WrAddr, WrData,
                 IssueEn, IssueAddr, Flush);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WrEn = 1'b0; IssueEn = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RdAddr = '0; WrAddr = '0; WrData = '0; IssueAddr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'h11; IssueEn = 1'b1; IssueAddr = 5'd5;
        RdAddr = {5'd5, 5'd5, 5'd5};
        tick();
        idle();
        #1;
        n_checks++; if (RdData[0] !== 32'h11) begin n_fail++; $display("FAIL reset_preload_data: got %h want %h", RdData[0], 32'h11); end
        n_checks++; if (PendingCnt !== 6'd1) begin n_fail++; $display("FAIL reset_preload_cnt: got %0d want 1", PendingCnt); end
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF; IssueEn = 1'b1; IssueAddr = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (RdData[0] !== 32'h0) begin n_fail++; $display("FAIL reset_held_data: got %h want 0", RdData[0]); end
        n_checks++; if (RdBusy !== 3'b000) begin n_fail++; $display("FAIL reset_held_busy: got %b want 000", RdBusy); end
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        n_checks++; if (RdData[0] !== 32'h0) begin n_fail++; $display("FAIL reset_x5_data: got %h want 0", RdData[0]); end
        n_checks++; if (PendingCnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", PendingCnt); end
        n_checks++; if (RdBusy !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b want 000", RdBusy); end
    endtask

    task automatic test_x0_write();
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFFFFFF; RdAddr = {5'd0, 5'd0, 5'd0};
        #1;
        n_checks++; if (RdData[0] !== 32'h0) begin n_fail++; $display("FAIL x0_same_cycle: got %h want 0", RdData[0]); end
        tick();
        idle();
        #1;
        n_checks++; if (RdData[0] !== 32'h0) begin n_fail++; $display("FAIL x0_data: got %h want 0", RdData[0]); end
        IssueEn = 1'b1; IssueAddr = 5'd0;
        tick();
        idle();
        n_checks++; if (PendingCnt !== 6'd0) begin n_fail++; $display("FAIL x0_issue_cnt: got %0d want 0", PendingCnt); end
        n_checks++; if (RdBusy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_issue_busy: got %b want 0", RdBusy[0]); end
    endtask

    task automatic test_scoreboard();
        IssueEn = 1'b1; IssueAddr = 5'd3;
        tick();
        IssueAddr = 5'd7;
        tick();
        idle();
        RdAddr[0] = 5'd3;
        #1;
        n_checks++; if (PendingCnt !== 6'd2) begin n_fail++; $display("FAIL sb_issue_cnt: got %0d want 2", PendingCnt); end
        n_checks++; if (RdBusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_x3_busy: got %b want 1", RdBusy[0]); end
        WrEn = 1'b1; WrAddr = 5'd3; WrData = 32'h12;
        tick();
        idle();
        #1;
        n_checks++; if (RdBusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wb_busy: got %b want 0", RdBusy[0]); end
        n_checks++; if (PendingCnt !== 6'd1) begin n_fail++; $display("FAIL sb_wb_cnt: got %0d want 1", PendingCnt); end
        n_checks++; if (RdData[0] !== 32'h12) begin n_fail++; $display("FAIL sb_wb_data: got %h want 12", RdData[0]); end
        IssueEn = 1'b1; IssueAddr = 5'd7;
        tick();
        idle();
        RdAddr[1] = 5'd7;
        #1;
        n_checks++; if (PendingCnt !== 6'd1) begin n_fail++; $display("FAIL sb_reissue_cnt: got %0d want 1", PendingCnt); end
        n_checks++; if (RdBusy[1] !== 1'b1) begin n_fail++; $display("FAIL sb_x7_busy: got %b want 1", RdBusy[1]); end
    endtask

    task automatic test_same_edge();
        IssueEn = 1'b1; IssueAddr = 5'd9;
        tick();
        WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'h99;
        tick();
        idle();
        RdAddr[0] = 5'd9;
        #1;
        n_checks++; if (RdBusy[0] !== 1'b1) begin n_fail++; $display("FAIL same_x9_busy: got %b want 1", RdBusy[0]); end
        n_checks++; if (PendingCnt !== 6'd2) begin n_fail++; $display("FAIL same_x9_cnt: got %0d want 2", PendingCnt); end
        n_checks++; if (RdData[0] !== 32'h99) begin n_fail++; $display("FAIL same_x9_data: got %h want 99", RdData[0]); end
        IssueEn = 1'b1; IssueAddr = 5'd12; WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h77;
        tick();
        idle();
        RdAddr = {5'd12, 5'd7, 5'd9};
        #1;
        n_checks++; if (PendingCnt !== 6'd2) begin n_fail++; $display("FAIL diff_regs_cnt: got %0d want 2", PendingCnt); end
        n_checks++; if (RdBusy !== 3'b101) begin n_fail++; $display("FAIL diff_regs_busy: got %b want 101", RdBusy); end
        Flush = 1'b1; IssueEn = 1'b1; IssueAddr = 5'd4; WrEn = 1'b1; WrAddr = 5'd4; WrData = 32'h44;
        tick();
        idle();
        RdAddr = {5'd12, 5'd9, 5'd4};
        #1;
        n_checks++; if (PendingCnt !== 6'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", PendingCnt); end
        n_checks++; if (RdBusy !== 3'b000) begin n_fail++; $display("FAIL flush_busy: got %b want 000", RdBusy); end
        n_checks++; if (RdData[0] !== 32'h44) begin n_fail++; $display("FAIL flush_data: got %h want 44", RdData[0]); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
        logic        exp_busy;
        WrEn = 1'b1; WrAddr = 5'd10; WrData = 32'h1;
        tick();
        idle();
        IssueEn = 1'b1; IssueAddr = 5'd10;
        tick();
        idle();
        WrEn = 1'b1; WrAddr = 5'd10; WrData = 32'hAB; RdAddr[0] = 5'd10;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        exp_data = 32'hAB; exp_busy = 1'b0;
`else
        exp_data = 32'h1;  exp_busy = 1'b1;
`endif
        n_checks++; if (RdData[0] !== exp_data) begin n_fail++; $display("FAIL bypass_same_data: got %h want %h", RdData[0], exp_data); end
        n_checks++; if (RdBusy[0] !== exp_busy) begin n_fail++; $display("FAIL bypass_same_busy: got %b want %b", RdBusy[0], exp_busy); end
        tick();
        idle();
        #1;
        n_checks++; if (RdData[0] !== 32'hAB) begin n_fail++; $display("FAIL bypass_next_data: got %h want ab", RdData[0]); end
        n_checks++; if (RdBusy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_next_busy: got %b want 0", RdBusy[0]); end
        n_checks++; if (PendingCnt !== 6'd0) begin n_fail++; $display("FAIL bypass_cnt: got %0d want 0", PendingCnt); end
    endtask

    task automatic test_multiport();
        logic [2:0][31:0] exp_mix;
        WrEn = 1'b1; WrAddr = 5'd31; WrData = 32'h5A5A5A5A;
        tick();
        idle();
        RdAddr = {5'd31, 5'd31, 5'd31};
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++; if (RdData[p] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL multiport_x31[%0d]: got %h want 5a5a5a5a", p, RdData[p]); end
        end
        RdAddr = {5'd4, 5'd9, 5'd3};
        exp_mix = {32'h44, 32'h99, 32'h12};
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++; if (RdData[p] !== exp_mix[p]) begin n_fail++; $display("FAIL multiport_mix[%0d]: got %h want %h", p, RdData[p], exp_mix[p]); end
        end
    endtask

    initial begin
        test_reset();
        test_x0_write();
        test_scoreboard();
        test_same_edge();
        test_bypass();
        test_multiport();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
